// File: rtl/traffic_phase_scheduler.sv
// Car/pedestrian crossing phase controller: latches button requests, enforces minimum car green,
// then runs yellow, all-red, walk, flashing-clear and all-red before returning to car green.
module traffic_phase_scheduler #(
    parameter int unsigned PRESCALE    = 1000000,
    parameter int unsigned T_MIN_GREEN = 30,
    parameter int unsigned T_YELLOW    = 4,
    parameter int unsigned T_ALLRED    = 2,
    parameter int unsigned T_WALK      = 10,
    parameter int unsigned T_FLASH     = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TESTMODE,
    input  logic       PED_REQ,
    output logic       G_CAR,
    output logic       Y_CAR,
    output logic       R_CAR,
    output logic       G_PEDES,
    output logic       R_PEDES,
    output logic       PED_WAIT,
    output logic [2:0] PHASE
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic [2:0] {
        StCarGreen = 3'd0,
        StYellow   = 3'd1,
        StAllRed1  = 3'd2,
        StWalk     = 3'd3,
        StFlash    = 3'd4,
        StAllRed2  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          flash_q, flash_d;
    logic          pending_q, pending_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          sync1_q, sync2_q, sync3_q;
    logic          tick;
    logic          ped_edge;

    function automatic logic [7:0] phase_len(input state_e s);
        case (s)
            StYellow:             phase_len = 8'(T_YELLOW - 1);
            StAllRed1, StAllRed2: phase_len = 8'(T_ALLRED - 1);
            StWalk:               phase_len = 8'(T_WALK - 1);
            StFlash:              phase_len = 8'(T_FLASH - 1);
            default:              phase_len = 8'(T_MIN_GREEN - 1);
        endcase
    endfunction

    // Test mode holds the prescaler at zero, so either direction of toggle restarts the count.
    always_comb begin
        presc_d = '0;
        tick    = 1'b1;
        if (!TESTMODE) begin
            tick = (presc_q == PW'(PRESCALE - 1));
            if (!tick) presc_d = presc_q + PW'(1);
        end
    end

    assign ped_edge = sync2_q & ~sync3_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        if (tick) begin
            if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                case (state_q)
                    StCarGreen: if (pending_q) state_d = StYellow;
                    StYellow:   state_d = StAllRed1;
                    StAllRed1:  state_d = StWalk;
                    StWalk:     state_d = StFlash;
                    StFlash:    state_d = StAllRed2;
                    default:    state_d = StCarGreen;
                endcase
            end
            if (state_q == StFlash) flash_d = ~flash_q;
        end
        // Codes 6 and 7 recover regardless of tick.
        if (state_q > StAllRed2) state_d = StCarGreen;
        if (state_d != state_q) begin
            cnt_d   = phase_len(state_d);
            flash_d = 1'b0;
        end
    end

    // Entry to WALK clears after the set so a coincident edge is dropped.
    always_comb begin
        pending_d = pending_q;
        if (ped_edge && state_q != StWalk && state_q != StFlash) pending_d = 1'b1;
        if (state_d == StWalk && state_q != StWalk) pending_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StCarGreen;
            cnt_q     <= 8'(T_MIN_GREEN - 1);
            flash_q   <= 1'b0;
            pending_q <= 1'b0;
            presc_q   <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flash_q   <= flash_d;
            pending_q <= pending_d;
            presc_q   <= presc_d;
            sync1_q   <= PED_REQ;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
        end
    end

    always_comb begin
        G_CAR   = 1'b0;
        Y_CAR   = 1'b0;
        R_CAR   = 1'b0;
        G_PEDES = 1'b0;
        R_PEDES = 1'b0;
        case (state_q)
            StYellow: begin
                Y_CAR   = 1'b1;
                R_PEDES = 1'b1;
            end
            StAllRed1, StAllRed2: begin
                R_CAR   = 1'b1;
                R_PEDES = 1'b1;
            end
            StWalk: begin
                R_CAR   = 1'b1;
                G_PEDES = 1'b1;
            end
            StFlash: begin
                R_CAR   = 1'b1;
                G_PEDES = flash_q;
            end
            default: begin
                G_CAR   = 1'b1;
                R_PEDES = 1'b1;
            end
        endcase
    end

    assign PED_WAIT = pending_q;
    assign PHASE    = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed and table-driven checks of the crossing phase scheduler, plus a random invariant run.
module tb_traffic_phase_scheduler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       TESTMODE;
    logic       PED_REQ;
    logic       G_CAR, Y_CAR, R_CAR, G_PEDES, R_PEDES, PED_WAIT;
    logic [2:0] PHASE;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] phase;
        int         len;
        logic       g_car;
        logic       y_car;
        logic       r_car;
        logic       g_ped;
        logic       r_ped;
        logic       flash;
    } seg_t;

    seg_t segs[5];

    traffic_phase_scheduler #(
        .PRESCALE(4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .TESTMODE(TESTMODE),
        .PED_REQ (PED_REQ),
        .G_CAR   (G_CAR),
        .Y_CAR   (Y_CAR),
        .R_CAR   (R_CAR),
        .G_PEDES (G_PEDES),
        .R_PEDES (R_PEDES),
        .PED_WAIT(PED_WAIT),
        .PHASE   (PHASE)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_phase(input logic [2:0] p, input int budget);
        int n;
        n = 0;
        while (PHASE !== p && n < budget) begin
            step();
            n++;
        end
        chk("wait_phase", {29'd0, PHASE}, {29'd0, p});
    endtask

    task automatic chk_green(input string name);
        chk({name, "_phase"}, {29'd0, PHASE}, 32'd0);
        chk({name, "_lights"}, {27'd0, G_CAR, Y_CAR, R_CAR, G_PEDES, R_PEDES}, 32'b10001);
    endtask

    initial begin
        int   n;
        logic ok;

        segs[0] = '{3'd1, 4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        segs[1] = '{3'd2, 2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        segs[2] = '{3'd3, 10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        segs[3] = '{3'd4, 6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        segs[4] = '{3'd5, 2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        RST      = 1'b1;
        TESTMODE = 1'b1;
        PED_REQ  = 1'b0;
        repeat (10) step();
        chk_green("reset");
        chk("reset_wait", {31'd0, PED_WAIT}, 32'd0);
        RST = 1'b0;

        // Early press: pressed after edge 3, request visible after edge 6, yellow at edge 30
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 3) PED_REQ = 1'b1;
            if (e == 10) PED_REQ = 1'b0;
            if (e == 5) chk("wait_edge5", {31'd0, PED_WAIT}, 32'd0);
            if (e == 6) chk("wait_edge6", {31'd0, PED_WAIT}, 32'd1);
            if (e == 29) chk("green_edge29", {29'd0, PHASE}, 32'd0);
        end

        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < segs[s].len; i++) begin
                chk("seq_phase", {29'd0, PHASE}, {29'd0, segs[s].phase});
                chk("seq_lights", {27'd0, G_CAR, Y_CAR, R_CAR, G_PEDES, R_PEDES},
                    {27'd0, segs[s].g_car, segs[s].y_car, segs[s].r_car,
                     segs[s].flash ? i[0] : segs[s].g_ped, segs[s].r_ped});
                step();
            end
        end
        chk_green("seq_return");
        chk("seq_return_wait", {31'd0, PED_WAIT}, 32'd0);

        // No request: green held
        for (int c = 0; c < 200; c++) begin
            step();
            chk("idle_green", {29'd0, PHASE}, 32'd0);
        end

        // Late press: yellow four edges after the press
        PED_REQ = 1'b1;
        step();
        step();
        chk("late_wait_n2", {31'd0, PED_WAIT}, 32'd0);
        step();
        chk("late_wait_n3", {31'd0, PED_WAIT}, 32'd1);
        chk("late_green_n3", {29'd0, PHASE}, 32'd0);
        step();
        chk("late_yellow_n4", {29'd0, PHASE}, 32'd1);
        PED_REQ = 1'b0;

        // Press during WALK is ignored; pending cleared on WALK entry
        wait_phase(3'd3, 20);
        chk("walk_entry_wait", {31'd0, PED_WAIT}, 32'd0);
        PED_REQ = 1'b1;
        repeat (4) step();
        PED_REQ = 1'b0;
        wait_phase(3'd4, 20);
        chk("walk_press_ignored", {31'd0, PED_WAIT}, 32'd0);

        // Press at ALLRED2 entry: next yellow exactly T_MIN_GREEN edges after green entry
        wait_phase(3'd5, 20);
        PED_REQ = 1'b1;
        step();
        chk("allred2_hold", {29'd0, PHASE}, 32'd5);
        step();
        chk_green("allred2_exit");
        step();
        chk("allred2_press_wait", {31'd0, PED_WAIT}, 32'd1);
        PED_REQ = 1'b0;
        for (int e = 2; e <= 30; e++) begin
            step();
            if (e == 29) chk("regreen_edge29", {29'd0, PHASE}, 32'd0);
        end
        chk("regreen_yellow", {29'd0, PHASE}, 32'd1);

        // Reset mid-WALK aborts immediately
        wait_phase(3'd3, 20);
        repeat (3) step();
        RST = 1'b1;
        #1;
        chk_green("midwalk_reset");
        chk("midwalk_reset_wait", {31'd0, PED_WAIT}, 32'd0);
        repeat (2) step();
        RST = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            chk("post_reset_idle", {29'd0, PHASE}, 32'd0);
        end

        // Prescaler: four clocks per tick
        RST = 1'b1;
        step();
        RST      = 1'b0;
        TESTMODE = 1'b0;
        PED_REQ  = 1'b1;
        repeat (5) step();
        PED_REQ = 1'b0;
        wait_phase(3'd1, 200);
        n = 0;
        while (PHASE === 3'd1 && n < 40) begin
            n++;
            step();
        end
        chk("presc_yellow_len", n, 32'd16);
        chk("presc_allred1", {29'd0, PHASE}, 32'd2);
        step();
        TESTMODE = 1'b1;
        step();
        chk("toggle_hold_a", {29'd0, PHASE}, 32'd2);
        TESTMODE = 1'b0;
        repeat (3) step();
        chk("toggle_hold_b", {29'd0, PHASE}, 32'd2);
        step();
        chk("toggle_walk", {29'd0, PHASE}, 32'd3);

        // Random run: light invariants
        RST = 1'b1;
        step();
        RST      = 1'b0;
        TESTMODE = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 15) == 0) PED_REQ = ~PED_REQ;
            if ($urandom_range(0, 199) == 0) TESTMODE = ~TESTMODE;
            step();
            ok = (PHASE <= 3'd5) && ($countones({G_CAR, Y_CAR, R_CAR}) == 1) &&
                 !(G_PEDES && R_PEDES) && (!(G_CAR || Y_CAR) || R_PEDES);
            chk("invariants", {31'd0, ok}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
